// File: rtl/ramp_sequencer.sv
// Sequencer for the 12-bit delta-Y ramp accumulator: latches a ramp profile on start, issues
// evenly spaced delta pulses, shadows the ramp level and stops before the level would wrap.
module ramp_sequencer #(
  parameter int unsigned INT_W  = 16,
  parameter int unsigned STEP_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        cfg_y,
  input  logic [INT_W-1:0]  cfg_interval,
  input  logic [STEP_W-1:0] cfg_steps,
  input  logic              cfg_hold,
  input  logic              clear,
  output logic              ramp_enb,
  output logic              delta,
  output logic [1:0]        y_sel,
  output logic [11:0]       level,
  output logic [STEP_W-1:0] step_cnt,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [2:0] {StIdle, StArm, StWait, StStep, StDone, StHold} state_e;

  state_e              state_q, state_d;
  logic [INT_W-1:0]    interval_q;
  logic [STEP_W-1:0]   steps_q;
  logic                hold_q;
  logic [INT_W-1:0]    wait_q, wait_d;

  logic [12:0]         dy;
  logic [12:0]         lvl_upd;
  logic [STEP_W-1:0]   cnt_upd;
  logic                wrap;
  logic                short_int;
  logic                want_step;
  logic                ovf_set;

  always_comb begin
    unique case (y_sel)
      2'b00:   dy = 13'd0;
      2'b01:   dy = 13'd1;
      2'b10:   dy = 13'd16;
      default: dy = 13'd1290;
    endcase
  end

  // Level/count as they will be after this edge; the wrap guard looks one delta ahead of that.
  assign lvl_upd   = {1'b0, level} + ((state_q == StStep) ? dy : 13'd0);
  assign cnt_upd   = step_cnt + STEP_W'(state_q == StStep);
  assign wrap      = (lvl_upd + dy) > 13'd4095;
  assign short_int = interval_q <= INT_W'(1);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    want_step = 1'b0;
    ovf_set   = 1'b0;
    case (state_q)
      StIdle: if (start) state_d = StArm;
      StArm: begin
        if (steps_q == '0) begin
          state_d = StDone;
        end else if (short_int) begin
          want_step = 1'b1;
        end else begin
          state_d = StWait;
          wait_d  = interval_q - INT_W'(2);
        end
      end
      StWait: begin
        if (wait_q == '0) want_step = 1'b1;
        else              wait_d = wait_q - INT_W'(1);
      end
      StStep: begin
        if (cnt_upd == steps_q) begin
          state_d = StDone;
        end else if (short_int) begin
          want_step = 1'b1;
        end else begin
          state_d = StWait;
          wait_d  = interval_q - INT_W'(2);
        end
      end
      StDone: state_d = hold_q ? StHold : StIdle;
      StHold: if (clear || start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (want_step) begin
      if (wrap) begin
        state_d = StDone;
        ovf_set = 1'b1;
      end else begin
        state_d = StStep;
      end
    end
    if (abort) begin
      state_d = StIdle;
      ovf_set = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      interval_q <= '0;
      steps_q    <= '0;
      hold_q     <= 1'b0;
      y_sel      <= 2'b00;
      level      <= '0;
      step_cnt   <= '0;
      ovf        <= 1'b0;
      ramp_enb   <= 1'b0;
      delta      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == StIdle && state_d == StArm) begin
        y_sel      <= cfg_y;
        interval_q <= cfg_interval;
        steps_q    <= cfg_steps;
        hold_q     <= cfg_hold;
        level      <= '0;
        step_cnt   <= '0;
        ovf        <= 1'b0;
      end else begin
        if (state_q == StStep && !abort) begin
          level    <= lvl_upd[11:0];
          step_cnt <= cnt_upd;
        end
        if (ovf_set) ovf <= 1'b1;
        // Ramp is cleared whenever we drop back to idle.
        if (state_d == StIdle && state_q != StIdle) level <= '0;
      end
      ramp_enb <= (state_d != StIdle);
      delta    <= (state_d == StStep);
      busy     <= (state_d == StArm) || (state_d == StWait) || (state_d == StStep);
      done     <= (state_d == StDone);
    end
  end

endmodule
